// File: rtl/inst_rom_resp_pkg.sv
// ============================================================================
// Module      : inst_rom_resp_pkg
// Description : Shared bus widths, enable/reset levels, FSM states and the
//               fetch/load address legality check for the instruction ROM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package inst_rom_resp_pkg;

    localparam int          c_inst_addr_bus  = 32;
    localparam int          c_inst_bus       = 32;
    localparam logic [31:0] c_zero_v         = 32'h0000_0000;
    localparam logic        c_chip_enable    = 1'b1;
    localparam logic        c_chip_disable   = 1'b0;
    localparam logic        c_rst_enable     = 1'b0;
    localparam int          c_mem_depth_log2 = 10;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Word aligned and every bit above the word index is zero.
    function automatic logic addr_ok(input logic [31:0] a, input int aw);
        return (a[1:0] == 2'b00) && ((a >> (aw + 2)) == 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_rom_array.sv
// ============================================================================
// Module      : inst_rom_array
// Description : Single-write, single synchronous-read word memory with
//               write-first behaviour on a same-address collision. No reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_rom_array
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W = c_mem_depth_log2
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [c_inst_bus-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [c_inst_bus-1:0] o_rdata
);

    logic [c_inst_bus-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [c_inst_bus-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/inst_rom_resp.sv
// ============================================================================
// Module      : inst_rom_resp
// Description : Instruction ROM responder: post-reset clear sweep, program
//               load port and a one-cycle registered fetch with error flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W = c_mem_depth_log2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic [c_inst_addr_bus-1:0] addr,
    output logic [c_inst_bus-1:0]      inst,
    output logic                       inst_valid,
    output logic                       fetch_err,
    output logic                       ready,
    input  logic                       ld_we,
    input  logic [c_inst_addr_bus-1:0] ld_addr,
    input  logic [c_inst_bus-1:0]      ld_data
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_cnt;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_good;

    logic                  w_fetch_ok;
    logic                  w_ld_ok;
    logic                  w_mem_we;
    logic [ADDR_W-1:0]     w_mem_waddr;
    logic [c_inst_bus-1:0] w_mem_wdata;
    logic                  w_valid_nxt;
    logic                  w_err_nxt;
    logic                  w_good_nxt;
    logic [c_inst_bus-1:0] w_rdata;

    assign w_fetch_ok = addr_ok(addr, ADDR_W);
    assign w_ld_ok    = addr_ok(ld_addr, ADDR_W);

    always_comb begin
        w_state_nxt = r_state;
        w_mem_we    = 1'b0;
        w_mem_waddr = ld_addr[ADDR_W+1:2];
        w_mem_wdata = ld_data;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_good_nxt  = 1'b0;
        case (r_state)
            ST_INIT: begin
                // The sweep owns the write port; fetch and load inputs are ignored.
                w_mem_we    = 1'b1;
                w_mem_waddr = r_cnt;
                w_mem_wdata = c_zero_v;
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_mem_we = ld_we && w_ld_ok;
                if (ce == c_chip_enable) begin
                    w_valid_nxt = 1'b1;
                    w_err_nxt   = !w_fetch_ok;
                    w_good_nxt  = w_fetch_ok;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_rst_enable) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_good  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_good  <= w_good_nxt;
        end
    end

    inst_rom_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_re    (w_good_nxt),
        .i_raddr (addr[ADDR_W+1:2]),
        .o_rdata (w_rdata)
    );

    // The array's read register has no reset, so the data is gated by the
    // reset-cleared good-fetch flag to make reset take effect immediately.
    assign inst       = r_good ? w_rdata : c_zero_v;
    assign inst_valid = r_valid;
    assign fetch_err  = r_err;
    assign ready      = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_resp.sv
// ============================================================================
// Module      : tb_inst_rom_resp
// Description : Self-checking bench for inst_rom_resp against a word-array
//               reference model with directed and randomized traffic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_inst_rom_resp;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        ce      = 1'b0;
    logic [31:0] addr    = 32'h0;
    logic        ld_we   = 1'b0;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic        ready;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    inst_rom_resp #(
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .addr       (addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .fetch_err  (fetch_err),
        .ready      (ready),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data)
    );

    function automatic bit in_map(input logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return 32'($urandom_range(0, 31)) * 4;
            1:       return 32'($urandom_range(0, DEPTH - 1)) * 4;
            2:       return DEPTH * 4 - 4;
            3:       return (32'($urandom_range(0, 31)) * 4) | 32'($urandom_range(1, 3));
            4:       return DEPTH * 4 + 32'($urandom_range(0, 255)) * 4;
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle of inputs, advance one edge and return the model's view.
    task automatic apply(input bit c, input logic [31:0] a, input bit w,
                         input logic [31:0] wa, input logic [31:0] wd,
                         output logic [31:0] e_inst, output bit e_v, output bit e_e);
        ce = c; addr = a; ld_we = w; ld_addr = wa; ld_data = wd;
        @(posedge clk); #1;
        if (w && in_map(wa)) model_mem[wa / 4] = wd;
        e_inst = 32'h0; e_v = 1'b0; e_e = 1'b0;
        if (c) begin
            e_v = 1'b1;
            if (in_map(a)) e_inst = model_mem[a / 4];
            else           e_e = 1'b1;
        end
    endtask

    task automatic wait_ready(input bit junk, output int n);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            if (junk) begin
                ce = 1'b1; addr = $urandom & 32'h0000_0FFC;
                ld_we = 1'b1; ld_addr = 32'h20; ld_data = 32'h1;
            end else begin
                ce = 1'b0; ld_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            n_cmp++;
            if ({inst_valid, fetch_err, inst} !== 34'h0) begin
                n_bad++;
                $display("FAIL init_outputs cycle %0d got v=%b e=%b inst=%h want 0/0/0",
                         n, inst_valid, fetch_err, inst);
            end
            if (ready) break;
        end
        ce = 1'b0; ld_we = 1'b0;
        if (!ready) begin
            n_bad++;
            $display("FAIL ready_timeout got ready=0 after %0d cycles want 1", n);
        end
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    task automatic test_reset();
        int n;
        #1;
        n_cmp++;
        if ({ready, inst_valid, fetch_err, inst} !== 35'h0) begin
            n_bad++;
            $display("FAIL reset_state got r=%b v=%b e=%b inst=%h want all 0",
                     ready, inst_valid, fetch_err, inst);
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        wait_ready(1'b1, n);
        n_cmp++;
        if (n !== 1024) begin
            n_bad++;
            $display("FAIL sweep_length got %0d want 1024", n);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] a_list [6] = '{32'h0, 32'hFFC, 32'h20, 32'h6, 32'h1000, 32'h8000_0000};
        logic [31:0] ei; bit ev, ee;
        foreach (a_list[k]) begin
            apply(1'b1, a_list[k], 1'b0, 32'h0, 32'h0, ei, ev, ee);
            n_cmp++;
            if ({inst_valid, fetch_err, inst} !== {ev, ee, ei}) begin
                n_bad++;
                $display("FAIL boundary addr=%h got v=%b e=%b inst=%h want v=%b e=%b inst=%h",
                         a_list[k], inst_valid, fetch_err, inst, ev, ee, ei);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ei; bit ev, ee;
        apply(1'b0, 32'h0, 1'b1, 32'h4, 32'h2402_0005, ei, ev, ee);
        apply(1'b0, 32'h0, 1'b1, 32'h8, 32'h3C01_1234, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== 34'h0) begin
            n_bad++;
            $display("FAIL idle_zero got v=%b e=%b inst=%h want 0/0/0", inst_valid, fetch_err, inst);
        end
        apply(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'h2402_0005}) begin
            n_bad++;
            $display("FAIL b2b_first got v=%b e=%b inst=%h want 1/0/24020005",
                     inst_valid, fetch_err, inst);
        end
        apply(1'b1, 32'h8, 1'b0, 32'h0, 32'h0, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'h3C01_1234}) begin
            n_bad++;
            $display("FAIL b2b_second got v=%b e=%b inst=%h want 1/0/3c011234",
                     inst_valid, fetch_err, inst);
        end
    endtask

    task automatic test_write_first();
        logic [31:0] ei; bit ev, ee;
        apply(1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL write_first got v=%b e=%b inst=%h want 1/0/deadbeef",
                     inst_valid, fetch_err, inst);
        end
    endtask

    task automatic test_random();
        logic [31:0] ei; bit ev, ee;
        logic [31:0] a, wa;
        for (int i = 0; i < 400; i++) begin
            a  = rand_addr();
            wa = ($urandom_range(0, 1) == 1) ? a : rand_addr();
            apply(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)), wa, $urandom,
                  ei, ev, ee);
            n_cmp++;
            if ({inst_valid, fetch_err, inst} !== {ev, ee, ei}) begin
                n_bad++;
                $display("FAIL random i=%0d addr=%h got v=%b e=%b inst=%h want v=%b e=%b inst=%h",
                         i, a, inst_valid, fetch_err, inst, ev, ee, ei);
            end
        end
    endtask

    task automatic check_reset_now(input string tag);
        #1;
        n_cmp++;
        if ({ready, inst_valid, fetch_err, inst} !== 35'h0) begin
            n_bad++;
            $display("FAIL %s got r=%b v=%b e=%b inst=%h want all 0",
                     tag, ready, inst_valid, fetch_err, inst);
        end
    endtask

    task automatic test_reset_during_fetch();
        logic [31:0] ei; bit ev, ee;
        int n;
        apply(1'b0, 32'h0, 1'b1, 32'h40, 32'hCAFE_F00D, ei, ev, ee);
        apply(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL pre_reset_fetch got v=%b e=%b inst=%h want 1/0/cafef00d",
                     inst_valid, fetch_err, inst);
        end
        #2 rst = 1'b0;
        check_reset_now("reset_in_run");
        ce = 1'b0;
        @(posedge clk); #3 rst = 1'b1;
        wait_ready(1'b0, n);
        n_cmp++;
        if (n !== 1024) begin
            n_bad++;
            $display("FAIL sweep_after_run_reset got %0d want 1024", n);
        end
        apply(1'b1, 32'h40, 1'b0, 32'h0, 32'h0, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL cleared_word got v=%b e=%b inst=%h want 1/0/0", inst_valid, fetch_err, inst);
        end
    endtask

    task automatic test_reset_mid_sweep();
        logic [31:0] ei; bit ev, ee;
        int n;
        apply(1'b0, 32'h0, 1'b1, 32'h4, 32'h1234_5678, ei, ev, ee);
        #2 rst = 1'b0;
        check_reset_now("reset_before_sweep");
        @(posedge clk); #3 rst = 1'b1;
        repeat (500) @(posedge clk);
        #3 rst = 1'b0;
        check_reset_now("reset_mid_sweep");
        @(posedge clk); #3 rst = 1'b1;
        wait_ready(1'b0, n);
        n_cmp++;
        if (n !== 1024) begin
            n_bad++;
            $display("FAIL sweep_after_mid_reset got %0d want 1024", n);
        end
        apply(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, ei, ev, ee);
        n_cmp++;
        if ({inst_valid, fetch_err, inst} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL loaded_word_cleared got v=%b e=%b inst=%h want 1/0/0",
                     inst_valid, fetch_err, inst);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        test_reset();
        test_boundary();
        test_back_to_back();
        test_write_first();
        test_random();
        test_reset_during_fetch();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 Parameter: ADDR_W, default 10, log2 of the memory depth in 32-bit words (1024 words).
REQ-002 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-low (0 = reset asserted).
REQ-004 Port: ce  in  1  fetch chip-enable from the fetch stage; 1 = fetch requested this cycle.
REQ-005 Port: addr  in  32  byte address of the instruction to fetch.
REQ-006 Port: inst  out  32  fetched instruction word, registered.
REQ-007 Port: inst_valid  out  1  inst holds the response to a fetch accepted in the previous cycle.
REQ-008 Port: fetch_err  out  1  previous accepted fetch was misaligned or out of range; qualifies inst.
REQ-009 Port: ready  out  1  1 once the post-reset clear sweep has completed.
REQ-010 Port: ld_we  in  1  program-load write strobe.
REQ-011 Port: ld_addr  in  32  program-load byte address.
REQ-012 Port: ld_data  in  32  program-load write data.

Function
REQ-013 States: INIT (clear sweep) and RUN; reset enters INIT with sweep counter 0.
REQ-014 INIT: one word written to 0 per cycle at index = counter; counter +1 per cycle.
REQ-015 INIT -> RUN on the edge that clears index 2^ADDR_W-1; ready = 1 from the following cycle; RUN is held until reset.
REQ-016 INIT: ce and ld_we ignored; inst = 0, inst_valid = 0, fetch_err = 0.
REQ-017 RUN, fetch accepted when ce = 1: word index = addr[ADDR_W+1:2]; result registered with exactly 1 cycle of latency.
REQ-018 RUN, ce = 0: on the next edge inst = 0, inst_valid = 0, fetch_err = 0.
REQ-019 Misaligned fetch (addr[1:0] != 0): inst = 0, inst_valid = 1, fetch_err = 1.
REQ-020 Out-of-range fetch (any addr[31:ADDR_W+2] != 0): inst = 0, inst_valid = 1, fetch_err = 1.
REQ-021 Good fetch: inst = mem[index], inst_valid = 1, fetch_err = 0.
REQ-022 RUN, ld_we = 1, ld_addr aligned and in range: mem[ld_addr[ADDR_W+1:2]] <= ld_data on that edge.
REQ-023 Load to a misaligned or out-of-range address: silently dropped; memory unchanged.
REQ-024 Load and fetch to the same word in the same cycle: write-first; inst returns ld_data.
REQ-025 Fetches on consecutive cycles: fully pipelined, one response per cycle, no bubbles.
REQ-026 Index arithmetic is unsigned, with no wrap: the top address (0xFFC for ADDR_W = 10) is valid and 0x1000 is out of range.

Reset
REQ-027 Reset asserted (rst = 0) at any time, including mid-sweep or mid-fetch: immediately inst = 0, inst_valid = 0, fetch_err = 0, ready = 0, state = INIT, counter = 0.
REQ-028 On reset release: the clear sweep restarts from index 0.
REQ-029 Memory array contents are not reset asynchronously; only the sweep clears them.

Structure
REQ-030 Shared defines header holds: inst_addr_bus, inst_bus, zero_v, chip_enable/chip_disable, rst_enable (= 0 for this block), and the new mem_depth_log2 default.
REQ-031 One sub-module, inst_rom_array: single write port, single synchronous read port, no reset, write-first on collision.
REQ-032 FSM, sweep counter, range/alignment checks and the output register live in inst_rom_resp.

Verification
REQ-033 Reset release -> ready = 0 for 1024 cycles, then ready = 1; fetches of 0x000 and 0xFFC return inst = 0, fetch_err = 0.
REQ-034 Load 0x24020005 at 0x004 and 0x3C011234 at 0x008, then ce = 1 with addr 0x004 and 0x008 on back-to-back cycles -> inst = 0x24020005 then 0x3C011234 on the next two cycles, inst_valid = 1 on both.
REQ-035 ce = 1, addr = 0x006 -> next cycle inst = 0, inst_valid = 1, fetch_err = 1; addr = 0x1000 -> same response.
REQ-036 Same cycle: ld_we = 1, ld_addr = 0x010, ld_data = 0xDEADBEEF, and ce = 1, addr = 0x010 -> next cycle inst = 0xDEADBEEF.
REQ-037 rst = 0 pulsed mid-sweep (cycle 500) and again during a RUN fetch -> outputs drop to 0 within the same cycle; after release, ready rises exactly 1024 cycles later; a previously loaded word reads 0.
REQ-038 ld_we = 1 during INIT, ld_addr = 0x020, ld_data = 0x1 -> after ready, a fetch of 0x020 returns 0.
